aes_stream_framer: RTL

Upstream framing stage for the S-box stream cipher datapath. Accepts a byte stream over a valid/ready handshake in which each frame is one key byte followed by zero or more payload bytes, and converts it into the cipher's `new_msg`/`key`/`in_valid`/`in` control. Guarantees that `new_msg` always precedes the first payload `in_valid` by at least one cycle and never coincides with one. Reports per-message length and completion.

---
 rtl/aes_stream_framer_if.sv | 10 +
 rtl/aes_stream_framer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/aes_stream_framer_if.sv
// Upstream byte stream into aes_stream_framer: valid/ready handshake with a last-byte marker.
interface aes_stream_framer_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/aes_stream_framer.sv
// Converts a key+payload byte stream into new_msg/key/in_valid/in control for the S-box stream cipher.
// Optional payload length limit with a DROP state is enabled by defining AES_FRAMER_LENCHK_EN.
module aes_stream_framer #(
    parameter int CNT_W   = 16,
    parameter int MAX_LEN = 255
) (
    input  logic               clk,
    input  logic               rst,
    aes_stream_framer_if.slave s,
    output logic               new_msg,
    output logic [7:0]         key,
    output logic               in_valid,
    output logic [7:0]         in,
    output logic               msg_done,
    output logic [CNT_W-1:0]   msg_len,
    output logic               len_err
);
    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PAYLOAD
`ifdef AES_FRAMER_LENCHK_EN
        , DROP
`endif
    } state_t;

    state_t             state, state_nxt;
    logic               ready_q;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               accept;
    logic               new_msg_nxt, in_valid_nxt, msg_done_nxt;
    logic [7:0]         key_nxt, in_nxt;
    logic [CNT_W-1:0]   msg_len_nxt;
`ifdef AES_FRAMER_LENCHK_EN
    logic               len_err_nxt;
`endif

    // Ready is held low while reset is asserted so nothing is accepted mid-reset.
    assign s.s_ready = ready_q & ~rst;
    assign accept    = s.s_valid & s.s_ready;
    assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        new_msg_nxt  = 1'b0;
        in_valid_nxt = 1'b0;
        msg_done_nxt = 1'b0;
        key_nxt      = key;
        in_nxt       = in;
        msg_len_nxt  = msg_len;
`ifdef AES_FRAMER_LENCHK_EN
        len_err_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    key_nxt     = s.s_data;
                    new_msg_nxt = 1'b1;
                    cnt_nxt     = '0;
                    if (s.s_last) begin
                        msg_done_nxt = 1'b1;
                        msg_len_nxt  = '0;
                    end else begin
                        state_nxt = ARM;
                    end
                end
            end
            // One dead cycle keeps new_msg strictly ahead of the first in_valid.
            ARM: state_nxt = PAYLOAD;
            PAYLOAD: begin
                if (accept) begin
                    in_nxt       = s.s_data;
                    in_valid_nxt = 1'b1;
                    cnt_nxt      = cnt_inc;
                    if (s.s_last) begin
                        msg_done_nxt = 1'b1;
                        msg_len_nxt  = cnt_inc;
                        state_nxt    = IDLE;
                    end
`ifdef AES_FRAMER_LENCHK_EN
                    else if (cnt_inc == CNT_W'(MAX_LEN)) begin
                        msg_done_nxt = 1'b1;
                        msg_len_nxt  = cnt_inc;
                        len_err_nxt  = 1'b1;
                        state_nxt    = DROP;
                    end
`endif
                end
            end
`ifdef AES_FRAMER_LENCHK_EN
            DROP: begin
                if (accept && s.s_last) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            cnt      <= '0;
            new_msg  <= 1'b0;
            in_valid <= 1'b0;
            msg_done <= 1'b0;
            key      <= '0;
            in       <= '0;
            msg_len  <= '0;
        end else begin
            state    <= state_nxt;
            ready_q  <= (state_nxt != ARM);
            cnt      <= cnt_nxt;
            new_msg  <= new_msg_nxt;
            in_valid <= in_valid_nxt;
            msg_done <= msg_done_nxt;
            key      <= key_nxt;
            in       <= in_nxt;
            msg_len  <= msg_len_nxt;
        end
    end

`ifdef AES_FRAMER_LENCHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            len_err <= 1'b0;
        end else begin
            len_err <= len_err_nxt;
        end
    end
`else
    logic unused_max_len;
    assign unused_max_len = ^MAX_LEN;
    assign len_err        = 1'b0;
`endif

endmodule
